// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 2-flop input synchroniser, 3-sample majority per bit,
// optional odd/even parity, 1 or 2 stop bits, break (line-low) recovery.
module uart_rx_param #(
    parameter int CLKS_PER_BIT = 8700,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
    input  logic                 i_clock,
    input  logic                 i_reset_n,
    input  logic                 i_rx_serial,
    output logic                 o_rx_dv,
    output logic [DATA_BITS-1:0] o_rx_byte,
    output logic                 o_parity_err,
    output logic                 o_frame_err,
    output logic                 o_busy
);

    localparam int H = (CLKS_PER_BIT - 1) / 2;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_S0   = CNT_W'(H - 1);
    localparam logic [CNT_W-1:0] CNT_S1   = CNT_W'(H);
    localparam logic [CNT_W-1:0] CNT_S2   = CNT_W'(H + 1);
    localparam logic [3:0]       LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0]       LAST_STOP = 4'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_DONE, S_WAITHI
    } state_t;

    state_t               state, state_nxt;
    logic                 rx_meta, rx_sync;
    logic [CNT_W-1:0]     cnt;
    logic [3:0]           bit_cnt;
    logic                 samp0, samp1;
    logic                 maj, at_mid, last_stop;
    logic [DATA_BITS-1:0] shreg;
    logic                 perr_q, ferr_q;

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= i_rx_serial;
            rx_sync <= rx_meta;
        end
    end

    // Third sample is the live synced bit at count H+1, so the decision lands on that cycle.
    assign at_mid    = (cnt == CNT_S2);
    assign maj       = (samp0 & samp1) | (samp0 & rx_sync) | (samp1 & rx_sync);
    assign last_stop = (state == S_STOP) && at_mid && (bit_cnt == LAST_STOP);

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) state <= S_IDLE;
        else            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:   if (!rx_sync) state_nxt = S_START;
            S_START:  if (at_mid) state_nxt = maj ? S_IDLE : S_DATA;
            S_DATA:   if (at_mid && bit_cnt == LAST_DATA)
                          state_nxt = (PARITY != 0) ? S_PARITY : S_STOP;
            S_PARITY: if (at_mid) state_nxt = S_STOP;
            S_STOP:   if (last_stop) state_nxt = S_DONE;
            S_DONE:   state_nxt = o_frame_err ? S_WAITHI : S_IDLE;
            S_WAITHI: if (rx_sync && cnt == CNT_LAST) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // o_rx_dv is a single-cycle strobe with no back-pressure; byte and flags are valid with it.
    always_comb begin
        o_rx_dv = (state == S_DONE);
        o_busy  = (state != S_IDLE);
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            cnt          <= '0;
            bit_cnt      <= '0;
            samp0        <= 1'b1;
            samp1        <= 1'b1;
            shreg        <= '0;
            perr_q       <= 1'b0;
            ferr_q       <= 1'b0;
            o_rx_byte    <= '0;
            o_parity_err <= 1'b0;
            o_frame_err  <= 1'b0;
        end else begin
            // Counter keeps running from START into DATA, so every later bit samples mid-bit.
            unique case (state_nxt)
                S_IDLE, S_DONE: cnt <= '0;
                S_START:  cnt <= (state == S_START) ? cnt + CNT_W'(1) : '0;
                S_WAITHI: cnt <= (state != S_WAITHI || !rx_sync || cnt == CNT_LAST) ?
                                 '0 : cnt + CNT_W'(1);
                default:  cnt <= (cnt == CNT_LAST) ? '0 : cnt + CNT_W'(1);
            endcase

            if (cnt == CNT_S0) samp0 <= rx_sync;
            if (cnt == CNT_S1) samp1 <= rx_sync;

            if (state_nxt != state)
                bit_cnt <= '0;
            else if (at_mid && (state == S_DATA || state == S_STOP))
                bit_cnt <= bit_cnt + 4'd1;

            if (state == S_DATA && at_mid)
                shreg <= {maj, shreg[DATA_BITS-1:1]};

            if (state == S_START)
                perr_q <= 1'b0;
            else if (state == S_PARITY && at_mid)
                perr_q <= (PARITY != 0) && ((^shreg ^ maj) != (PARITY == 1));

            if (state == S_START)
                ferr_q <= 1'b0;
            else if (state == S_STOP && at_mid)
                ferr_q <= ferr_q | ~maj;

            if (last_stop) begin
                o_rx_byte    <= shreg;
                o_parity_err <= perr_q;
                o_frame_err  <= ferr_q | ~maj;
            end
        end
    end

endmodule
